// File: rtl/dcache_flush.sv
// Blocking write-back, write-allocate set-associative L1 data cache with tree-PLRU
// replacement and a flush engine that writes back every dirty line on request.
module dcache_flush #(
  parameter int WAYS       = 4,
  parameter int SETS       = 16,
  parameter int LINE_BYTES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             ufp_addr,
  input  logic [3:0]              ufp_rmask,
  input  logic [3:0]              ufp_wmask,
  input  logic [31:0]             ufp_wdata,
  output logic [31:0]             ufp_rdata,
  output logic                    ufp_resp,
  output logic [31:0]             dfp_addr,
  output logic                    dfp_read,
  output logic                    dfp_write,
  input  logic [8*LINE_BYTES-1:0] dfp_rdata,
  output logic [8*LINE_BYTES-1:0] dfp_wdata,
  input  logic                    dfp_resp,
  input  logic                    flush_req,
  output logic                    flush_done
);

  localparam int SET_BITS    = $clog2(SETS);
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int TAG_BITS    = 32 - SET_BITS - OFFSET_BITS;
  localparam int WAY_BITS    = $clog2(WAYS);
  localparam int WORD_BITS   = OFFSET_BITS - 2;
  localparam int LINE_BITS   = 8 * LINE_BYTES;
  localparam int IDX_BITS    = SET_BITS + WAY_BITS;

  typedef enum logic [2:0] {
    IDLE, COMPARE, WRITEBACK, ALLOCATE, FLUSH_SCAN, FLUSH_WB
  } state_e;

  state_e state_q, state_d;

  logic [31:2]           addr_q, addr_d;
  logic [3:0]            wmask_q, wmask_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [WAY_BITS-1:0]   victim_q, victim_d;
  logic [IDX_BITS:0]     flushIdx_q, flushIdx_d;

  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       dirty_q [SETS];
  logic [WAYS-2:0]       plru_q  [SETS];
  logic [TAG_BITS-1:0]   tag_q   [SETS][WAYS];
  logic [LINE_BITS-1:0]  data_q  [SETS][WAYS];

  logic                  unusedAddrLsbs;
  assign unusedAddrLsbs = ^ufp_addr[1:0];

  logic [TAG_BITS-1:0]   reqTag;
  logic [SET_BITS-1:0]   reqSet;
  logic [WORD_BITS-1:0]  reqWord;
  logic [SET_BITS-1:0]   flushSet;
  logic [WAY_BITS-1:0]   flushWay;

  assign reqTag   = addr_q[31 -: TAG_BITS];
  assign reqSet   = addr_q[OFFSET_BITS +: SET_BITS];
  assign reqWord  = addr_q[2 +: WORD_BITS];
  assign flushSet = flushIdx_q[WAY_BITS +: SET_BITS];
  assign flushWay = flushIdx_q[WAY_BITS-1:0];

  // Tree nodes are heap-ordered from the root; a node bit of 1 sends the victim walk right.
  function automatic logic [WAY_BITS-1:0] plruVictim(input logic [WAYS-2:0] tree);
    logic [WAY_BITS-1:0] node;
    logic [WAY_BITS-1:0] way;
    logic                dir;
    node = '0;
    way  = '0;
    for (int l = 0; l < WAY_BITS; l++) begin
      dir  = tree[node];
      way  = WAY_BITS'({way, dir});
      node = WAY_BITS'(32'(node) * 2 + 32'(dir) + 1);
    end
    return way;
  endfunction

  function automatic logic [WAYS-2:0] plruTouch(input logic [WAYS-2:0] tree,
                                                input logic [WAY_BITS-1:0] way);
    logic [WAYS-2:0]     result;
    logic [WAY_BITS-1:0] node;
    logic [WAY_BITS-1:0] rest;
    logic                dir;
    result = tree;
    node   = '0;
    rest   = way;
    for (int l = 0; l < WAY_BITS; l++) begin
      dir          = rest[WAY_BITS-1];
      rest         = rest << 1;
      result[node] = ~dir;
      node         = WAY_BITS'(32'(node) * 2 + 32'(dir) + 1);
    end
    return result;
  endfunction

  logic                 hit;
  logic [WAY_BITS-1:0]  hitWay;
  logic                 hasInvalid;
  logic [WAY_BITS-1:0]  invalidWay;
  logic [WAY_BITS-1:0]  victimWay;
  logic [LINE_BITS-1:0] hitLine;
  logic [31:0]          hitWord;
  logic [31:0]          mergedWord;
  logic [LINE_BITS-1:0] mergedLine;

  always_comb begin
    hit        = 1'b0;
    hitWay     = '0;
    hasInvalid = 1'b0;
    invalidWay = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[reqSet][w] && (tag_q[reqSet][w] == reqTag)) begin
        hit    = 1'b1;
        hitWay = WAY_BITS'(w);
      end
    end
    // Scanning downward leaves the lowest-index invalid way as the winner.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[reqSet][w]) begin
        hasInvalid = 1'b1;
        invalidWay = WAY_BITS'(w);
      end
    end
    victimWay  = hasInvalid ? invalidWay : plruVictim(plru_q[reqSet]);
    hitLine    = data_q[reqSet][hitWay];
    hitWord    = hitLine[{reqWord, 5'b0} +: 32];
    mergedWord = hitWord;
    for (int b = 0; b < 4; b++) begin
      if (wmask_q[b]) mergedWord[8*b +: 8] = wdata_q[8*b +: 8];
    end
    mergedLine = hitLine;
    mergedLine[{reqWord, 5'b0} +: 32] = mergedWord;
  end

  logic hitWriteEn, fillEn, plruTouchEn, flushCleanEn;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wmask_d      = wmask_q;
    wdata_d      = wdata_q;
    victim_d     = victim_q;
    flushIdx_d   = flushIdx_q;
    ufp_resp     = 1'b0;
    ufp_rdata    = '0;
    dfp_read     = 1'b0;
    dfp_write    = 1'b0;
    dfp_addr     = '0;
    dfp_wdata    = '0;
    flush_done   = 1'b0;
    hitWriteEn   = 1'b0;
    fillEn       = 1'b0;
    plruTouchEn  = 1'b0;
    flushCleanEn = 1'b0;
    case (state_q)
      IDLE: begin
        if ((|ufp_rmask) || (|ufp_wmask)) begin
          addr_d  = ufp_addr[31:2];
          wmask_d = ufp_wmask;
          wdata_d = ufp_wdata;
          state_d = COMPARE;
        end else if (flush_req) begin
          flushIdx_d = '0;
          state_d    = FLUSH_SCAN;
        end
      end
      COMPARE: begin
        if (hit) begin
          ufp_resp    = 1'b1;
          ufp_rdata   = hitWord;
          plruTouchEn = 1'b1;
          hitWriteEn  = |wmask_q;
          state_d     = IDLE;
        end else begin
          victim_d = victimWay;
          state_d  = (valid_q[reqSet][victimWay] && dirty_q[reqSet][victimWay]) ? WRITEBACK
                                                                               : ALLOCATE;
        end
      end
      WRITEBACK: begin
        dfp_write = 1'b1;
        dfp_addr  = {tag_q[reqSet][victim_q], reqSet, {OFFSET_BITS{1'b0}}};
        dfp_wdata = data_q[reqSet][victim_q];
        if (dfp_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        dfp_read = 1'b1;
        dfp_addr = {reqTag, reqSet, {OFFSET_BITS{1'b0}}};
        if (dfp_resp) begin
          fillEn  = 1'b1;
          state_d = COMPARE;
        end
      end
      FLUSH_SCAN: begin
        // The extra top counter bit marks that every set/way index has been visited.
        if (flushIdx_q[IDX_BITS]) begin
          flush_done = 1'b1;
          state_d    = IDLE;
        end else if (valid_q[flushSet][flushWay] && dirty_q[flushSet][flushWay]) begin
          state_d = FLUSH_WB;
        end else begin
          flushIdx_d = flushIdx_q + (IDX_BITS+1)'(1);
        end
      end
      FLUSH_WB: begin
        dfp_write = 1'b1;
        dfp_addr  = {tag_q[flushSet][flushWay], flushSet, {OFFSET_BITS{1'b0}}};
        dfp_wdata = data_q[flushSet][flushWay];
        if (dfp_resp) begin
          flushCleanEn = 1'b1;
          flushIdx_d   = flushIdx_q + (IDX_BITS+1)'(1);
          state_d      = FLUSH_SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wmask_q    <= '0;
      wdata_q    <= '0;
      victim_q   <= '0;
      flushIdx_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wmask_q    <= wmask_d;
      wdata_q    <= wdata_d;
      victim_q   <= victim_d;
      flushIdx_q <= flushIdx_d;
      if (fillEn) begin
        valid_q[reqSet][victim_q] <= 1'b1;
        dirty_q[reqSet][victim_q] <= 1'b0;
      end
      if (hitWriteEn) dirty_q[reqSet][hitWay] <= 1'b1;
      if (plruTouchEn) plru_q[reqSet] <= plruTouch(plru_q[reqSet], hitWay);
      if (flushCleanEn) dirty_q[flushSet][flushWay] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fillEn) begin
        data_q[reqSet][victim_q] <= dfp_rdata;
        tag_q[reqSet][victim_q]  <= reqTag;
      end else if (hitWriteEn) begin
        data_q[reqSet][hitWay] <= mergedLine;
      end
    end
  end

endmodule

// File: tb/tb_dcache_flush.sv
// Scoreboard bench for dcache_flush: stimulus pushes expected ufp/dfp events,
// a negedge monitor pops and compares them, and a line memory answers dfp requests.
module tb_dcache_flush;

  typedef struct {
    string       name;
    logic        checkData;
    logic [31:0] rdata;
  } ufpExp_t;

  typedef struct {
    string       name;
    logic        isWrite;
    logic [31:0] addr;
    int          wordIdx;
    logic [31:0] word;
  } dfpExp_t;

  logic         clk;
  logic         rst;
  logic [31:0]  ufp_addr;
  logic [3:0]   ufp_rmask;
  logic [3:0]   ufp_wmask;
  logic [31:0]  ufp_wdata;
  logic [31:0]  ufp_rdata;
  logic         ufp_resp;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_rdata;
  logic [255:0] dfp_wdata;
  logic         dfp_resp;
  logic         flush_req;
  logic         flush_done;

  int checks = 0;
  int passes = 0;
  ufpExp_t ufpQ[$];
  dfpExp_t dfpQ[$];
  logic [255:0] mem [logic [31:0]];

  dcache_flush dut (
    .clk(clk), .rst(rst),
    .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask), .ufp_wmask(ufp_wmask),
    .ufp_wdata(ufp_wdata), .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_rdata(dfp_rdata), .dfp_wdata(dfp_wdata), .dfp_resp(dfp_resp),
    .flush_req(flush_req), .flush_done(flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Untouched memory lines hold word k = {addr[31:8], 8'h00} + k.
  function automatic logic [255:0] lineFor(input logic [31:0] a);
    logic [255:0] l;
    if (mem.exists(a)) return mem[a];
    for (int k = 0; k < 8; k++) l[32*k +: 32] = {a[31:8], 8'h00} + 32'(k);
    return l;
  endfunction

  initial begin
    int rLat;
    dfp_resp  = 1'b0;
    dfp_rdata = '0;
    rLat      = 0;
    forever begin
      @(negedge clk);
      if (dfp_resp) begin
        dfp_resp = 1'b0;
        rLat     = 0;
      end else if (dfp_read || dfp_write) begin
        rLat++;
        if (rLat == 3) begin
          if (dfp_write) mem[dfp_addr] = dfp_wdata;
          else dfp_rdata = lineFor(dfp_addr);
          dfp_resp = 1'b1;
        end
      end else begin
        rLat = 0;
      end
    end
  end

  initial begin
    logic prevRd;
    logic prevWr;
    ufpExp_t ue;
    dfpExp_t de;
    prevRd = 1'b0;
    prevWr = 1'b0;
    forever begin
      @(negedge clk);
      if (ufp_resp) begin
        checkOutput("ufp_resp_expected", 32'(ufpQ.size() > 0), 32'd1);
        if (ufpQ.size() > 0) begin
          ue = ufpQ.pop_front();
          if (ue.checkData) checkOutput({ue.name, "_rdata"}, ufp_rdata, ue.rdata);
        end
      end
      if (dfp_read && dfp_write) checkOutput("dfp_read_write_exclusive", 32'd1, 32'd0);
      if ((dfp_read && !prevRd) || (dfp_write && !prevWr)) begin
        checkOutput("dfp_request_expected", 32'(dfpQ.size() > 0), 32'd1);
        if (dfpQ.size() > 0) begin
          de = dfpQ.pop_front();
          checkOutput({de.name, "_is_write"}, 32'(dfp_write), 32'(de.isWrite));
          checkOutput({de.name, "_addr"}, dfp_addr, de.addr);
          if (de.isWrite) checkOutput({de.name, "_wdata"}, dfp_wdata[32*de.wordIdx +: 32], de.word);
        end
      end
      prevRd = dfp_read;
      prevWr = dfp_write;
    end
  end

  task automatic expectDfp(input string name, input logic isWrite, input logic [31:0] addr,
                           input int wordIdx, input logic [31:0] word);
    dfpExp_t e;
    e.name = name; e.isWrite = isWrite; e.addr = addr; e.wordIdx = wordIdx; e.word = word;
    dfpQ.push_back(e);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ufp_resp", 32'(ufp_resp), 32'd0);
    checkOutput("reset_ufp_rdata", ufp_rdata, 32'd0);
    checkOutput("reset_dfp_read", 32'(dfp_read), 32'd0);
    checkOutput("reset_dfp_write", 32'(dfp_write), 32'd0);
    checkOutput("reset_dfp_addr", dfp_addr, 32'd0);
    checkOutput("reset_flush_done", 32'(flush_done), 32'd0);
    rst = 1'b0;
  endtask

  // expLat counts negedges from the acceptance edge to the ufp_resp sample.
  task automatic applyStimulus(input string name, input logic [31:0] addr, input logic [3:0] rmask,
                               input logic [3:0] wmask, input logic [31:0] wdata,
                               input logic checkData, input logic [31:0] expRdata, input int expLat);
    ufpExp_t e;
    int lat;
    int got;
    e.name = name; e.checkData = checkData; e.rdata = expRdata;
    ufpQ.push_back(e);
    @(negedge clk);
    ufp_addr = addr; ufp_rmask = rmask; ufp_wmask = wmask; ufp_wdata = wdata;
    @(posedge clk);
    #1;
    ufp_rmask = 4'b0; ufp_wmask = 4'b0;
    lat = 0;
    got = 0;
    while (lat < 300 && got == 0) begin
      @(negedge clk);
      lat++;
      if (ufp_resp) got = 1;
    end
    checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
  endtask

  task automatic runFlush(input string name, input int expLat);
    int n;
    int seen;
    @(negedge clk);
    flush_req = 1'b1;
    n = 0;
    seen = 0;
    while (n < 3000 && seen == 0) begin
      @(negedge clk);
      n++;
      if (flush_done) seen = 1;
    end
    flush_req = 1'b0;
    checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
    if (expLat > 0) checkOutput({name, "_latency"}, 32'(n), 32'(expLat));
    @(negedge clk);
    checkOutput({name, "_done_single_pulse"}, 32'(flush_done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    int respAt;
    int doneAt;
    int seen;
    ufpExp_t e;
    rst = 1'b0; ufp_addr = '0; ufp_rmask = '0; ufp_wmask = '0; ufp_wdata = '0; flush_req = 1'b0;

    // Cold fill, hits, byte-merge store, and combined read+write returning the pre-write word.
    doReset();
    expectDfp("cold_fill", 1'b0, 32'h0000_1040, 0, 32'h0);
    applyStimulus("cold_read", 32'h0000_1044, 4'hF, 4'h0, 32'h0, 1'b1, 32'h0000_1001, 5);
    applyStimulus("repeat_read", 32'h0000_1044, 4'hF, 4'h0, 32'h0, 1'b1, 32'h0000_1001, 1);
    applyStimulus("byte_write", 32'h0000_1044, 4'h0, 4'b0001, 32'h0000_00AA, 1'b0, 32'h0, 1);
    applyStimulus("read_after_write", 32'h0000_1044, 4'hF, 4'h0, 32'h0, 1'b1, 32'h0000_10AA, 1);
    applyStimulus("read_and_write", 32'h0000_1044, 4'hF, 4'b0010, 32'h0000_BB00, 1'b1, 32'h0000_10AA, 1);
    applyStimulus("read_merged", 32'h0000_1044, 4'hF, 4'h0, 32'h0, 1'b1, 32'h0000_BBAA, 1);

    // Five tags in set 2: the dirty way-0 line is the PLRU victim and is written back first.
    doReset();
    expectDfp("fill_0040", 1'b0, 32'h0000_0040, 0, 32'h0);
    applyStimulus("write_0040", 32'h0000_0040, 4'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0, 5);
    expectDfp("fill_0240", 1'b0, 32'h0000_0240, 0, 32'h0);
    applyStimulus("read_0240", 32'h0000_0240, 4'hF, 4'h0, 32'h0, 1'b1, 32'h0000_0200, 5);
    expectDfp("fill_0440", 1'b0, 32'h0000_0440, 0, 32'h0);
    applyStimulus("read_0440", 32'h0000_0440, 4'hF, 4'h0, 32'h0, 1'b1, 32'h0000_0400, 5);
    expectDfp("fill_0640", 1'b0, 32'h0000_0640, 0, 32'h0);
    applyStimulus("read_0640", 32'h0000_0640, 4'hF, 4'h0, 32'h0, 1'b1, 32'h0000_0600, 5);
    expectDfp("evict_0040", 1'b1, 32'h0000_0040, 0, 32'hDEAD_BEEF);
    expectDfp("fill_0840", 1'b0, 32'h0000_0840, 0, 32'h0);
    applyStimulus("read_0840", 32'h0000_0840, 4'hF, 4'h0, 32'h0, 1'b1, 32'h0000_0800, 9);
    expectDfp("refill_0040", 1'b0, 32'h0000_0040, 0, 32'h0);
    applyStimulus("reread_0040", 32'h0000_0040, 4'hF, 4'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 5);

    // Flush with two dirty lines, then a clean flush, then a read racing a flush request.
    doReset();
    expectDfp("fill_0040b", 1'b0, 32'h0000_0040, 0, 32'h0);
    applyStimulus("write_0040b", 32'h0000_0040, 4'h0, 4'hF, 32'h1234_5678, 1'b0, 32'h0, 5);
    expectDfp("fill_1040b", 1'b0, 32'h0000_1040, 0, 32'h0);
    applyStimulus("write_1044b", 32'h0000_1044, 4'h0, 4'b0001, 32'h0000_00AA, 1'b0, 32'h0, 5);
    expectDfp("flush_wb_0040", 1'b1, 32'h0000_0040, 0, 32'h1234_5678);
    expectDfp("flush_wb_1040", 1'b1, 32'h0000_1040, 1, 32'h0000_10AA);
    runFlush("flush_dirty", 0);
    checkOutput("flush_dirty_all_writebacks", 32'(dfpQ.size()), 32'd0);
    runFlush("flush_clean", 65);

    e.name = "race_read"; e.checkData = 1'b1; e.rdata = 32'h0000_10AA;
    ufpQ.push_back(e);
    @(negedge clk);
    ufp_addr = 32'h0000_1044; ufp_rmask = 4'hF; flush_req = 1'b1;
    @(posedge clk);
    #1;
    ufp_rmask = 4'h0;
    n = 0; respAt = 0; doneAt = 0;
    while (n < 3000 && doneAt == 0) begin
      @(negedge clk);
      n++;
      if (ufp_resp && respAt == 0) respAt = n;
      if (flush_done) doneAt = n;
    end
    flush_req = 1'b0;
    checkOutput("race_read_first", 32'(respAt), 32'd1);
    checkOutput("race_flush_after", 32'(doneAt), 32'd67);

    // Reset while a fill is outstanding drops dfp_read; the lost line misses again later.
    doReset();
    expectDfp("pending_2000", 1'b0, 32'h0000_2000, 0, 32'h0);
    @(negedge clk);
    ufp_addr = 32'h0000_2000; ufp_rmask = 4'hF;
    @(posedge clk);
    #1;
    ufp_rmask = 4'h0;
    n = 0; seen = 0;
    while (n < 50 && seen == 0) begin
      @(negedge clk);
      n++;
      if (dfp_read) seen = 1;
    end
    checkOutput("pending_read_seen", 32'(seen), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_drops_dfp_read", 32'(dfp_read), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expectDfp("refill_1040", 1'b0, 32'h0000_1040, 0, 32'h0);
    applyStimulus("read_after_reset", 32'h0000_1044, 4'hF, 4'h0, 32'h0, 1'b1, 32'h0000_10AA, 5);

    repeat (5) @(negedge clk);
    checkOutput("ufp_scoreboard_drained", 32'(ufpQ.size()), 32'd0);
    checkOutput("dfp_scoreboard_drained", 32'(dfpQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dcache_flush.md
Name: dcache_flush

Overview:
- Parametrised, blocking, write-back, write-allocate set-associative L1 data cache with a cache-maintenance flush port.
- Generalises line size, set count and way count. Adds in-block replacement, invalid-way-first fill, and a flush engine that writes back all dirty lines on request.
- Sits between the CPU load/store unit (ufp) and the memory arbiter/DRAM adapter (dfp). Arrays are internal flip-flop arrays; no SRAM macros.

Parameters:
- WAYS, 4: associativity; power of 2, at least 2.
- SETS, 16: number of sets; power of 2. SET_BITS = clog2(SETS).
- LINE_BYTES, 32: line size; power of 2, at least 8. OFFSET_BITS = clog2(LINE_BYTES). TAG_BITS = 32 - SET_BITS - OFFSET_BITS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ufp_addr  in  32  CPU byte address
- ufp_rmask  in  4  read byte mask; nonzero means read request
- ufp_wmask  in  4  write byte mask; nonzero means write request
- ufp_wdata  in  32  store data
- ufp_rdata  out  32  load data; valid with ufp_resp
- ufp_resp  out  1  one-cycle completion pulse
- dfp_addr  out  32  line-aligned memory address
- dfp_read  out  1  line fill request
- dfp_write  out  1  line writeback request
- dfp_rdata  in  8*LINE_BYTES  fill data
- dfp_wdata  out  8*LINE_BYTES  writeback data
- dfp_resp  in  1  memory completion pulse
- flush_req  in  1  request write-back of all dirty lines
- flush_done  out  1  one-cycle pulse when flush completes

Behaviour:
- Reset values: all valid and dirty bits 0; PLRU state 0; FSM in IDLE; ufp_resp, ufp_rdata, dfp_read, dfp_write, dfp_addr, flush_done all 0.
- Reset mid-operation: outstanding dfp_read/dfp_write are deasserted at the reset edge. A dfp_resp arriving later is ignored.
- Address split: tag = addr[31:SET_BITS+OFFSET_BITS]; set = addr[SET_BITS+OFFSET_BITS-1:OFFSET_BITS]; word = addr[OFFSET_BITS-1:2].
- Request acceptance: a request is accepted in IDLE when (|ufp_rmask | |ufp_wmask). On acceptance, addr, masks and wdata are registered; ufp inputs are don't-care afterwards.
- Both masks nonzero: treated as a write; ufp_rdata returns the pre-write word.
- Priority in IDLE: a ufp request is accepted before flush_req. flush_req is level-sampled and honoured once IDLE has no ufp request.
- FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE, FLUSH_SCAN, FLUSH_WB.
- IDLE -> COMPARE on request acceptance.
- COMPARE, hit: ufp_resp = 1 this cycle; ufp_rdata = hit word; for writes, masked bytes are merged and the line is marked dirty. Returns to IDLE. Hit latency is 1 cycle after acceptance.
- COMPARE, miss: victim = lowest-index invalid way, else the PLRU way. Dirty valid victim -> WRITEBACK; otherwise -> ALLOCATE.
- WRITEBACK: dfp_write = 1, dfp_addr = {victim tag, set, 0}, dfp_wdata = victim line, all held stable until dfp_resp. Then -> ALLOCATE.
- ALLOCATE: dfp_read = 1, dfp_addr = {tag, set, 0} until dfp_resp. At dfp_resp, the line is written with valid = 1, dirty = 0. Then -> COMPARE, which now hits.
- dfp_read and dfp_write are never asserted together; both deassert the cycle after dfp_resp.
- PLRU: tree PLRU per set, updated on every hit in COMPARE, including the post-fill hit.
- FLUSH_SCAN: an index counter walks set-major, way-minor, from 0 to SETS*WAYS-1. A valid dirty entry -> FLUSH_WB; otherwise the counter increments.
- FLUSH_WB: same handshake as WRITEBACK. On dfp_resp, clear that entry's dirty bit (the line stays valid), increment, return to FLUSH_SCAN.
- Flush completion: after the last index, flush_done pulses for 1 cycle and the FSM returns to IDLE. flush_req asserted during a flush is absorbed into the current flush. A flush with no dirty lines takes SETS*WAYS scan cycles and issues no dfp traffic.

Test Plan:
Defaults WAYS=4, SETS=16, LINE_BYTES=32 (set = addr[8:5], tag stride 0x200).
- Cold read 0x0000_1044 -> dfp_read with dfp_addr 0x0000_1040. Return a line with word k = 0x1000+k -> ufp_rdata 0x0000_1001. A repeat read gets ufp_resp 1 cycle after acceptance with no dfp activity.
- Write wmask 4'b0001, wdata 0x0000_00AA to 0x1044 after the fill -> a read of 0x1044 returns 0x0000_10AA; no dfp traffic.
- Write to 0x0040, then read 0x0240, 0x0440, 0x0640, 0x0840 (five tags in set 2). The fifth access issues dfp_write at 0x0000_0040 with the written data, before dfp_read of 0x0000_0840.
- Dirty 0x0040 and 0x1044, then flush_req -> exactly two dfp_write transfers, then a flush_done pulse. A second flush issues zero writes and pulses flush_done after 64 scan cycles.
- Assert rst while dfp_read is pending for 0x2000 -> dfp_read is 0 the next cycle. A later read of 0x1044 misses and issues dfp_read.
- flush_req and a read of 0x1044 in the same IDLE cycle -> the read completes first, then the flush runs.
